// File: rtl/sm83_alu_pch_pkg.sv
// Shared types and defaults for the ALU bus-slice precharge/evaluate sequencer.
package sm83_alu_pch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PCH    = 2'd1,
    EVAL   = 2'd2,
    SAMPLE = 2'd3
  } alu_pch_state_t;

  localparam int unsigned DEF_WIDTH       = 8;
  localparam int unsigned DEF_PCH_CYCLES  = 1;
  localparam int unsigned DEF_EVAL_CYCLES = 1;

  // Phase counter width: enough to hold the longer of the two phase lengths.
  function automatic int unsigned cnt_width(input int unsigned pch_cycles,
                                            input int unsigned eval_cycles);
    int unsigned longest;
    longest = (pch_cycles > eval_cycles) ? pch_cycles : eval_cycles;
    return (longest < 1) ? 1 : $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/sm83_pch_phase_counter.sv
// Loadable down-counter timing the precharge and evaluate phases.
module sm83_pch_phase_counter #(
  parameter int unsigned CNT_W = 1
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load wins over decrement; decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sm83_alu_pch_sequencer.sv
// Precharge/evaluate sequencer for one precharged ALU bus slice: drives the
// cells' pch_n and the bus pull-downs, and samples the inverted node values.
module sm83_alu_pch_sequencer
  import sm83_alu_pch_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned PCH_CYCLES  = DEF_PCH_CYCLES,
  parameter int unsigned EVAL_CYCLES = DEF_EVAL_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] y,
  output logic             pch_n,
  output logic [WIDTH-1:0] pd,
  output logic             busy,
  output logic             ack,
  output logic [WIDTH-1:0] q
);

  if ((PCH_CYCLES < 1) || (EVAL_CYCLES < 1)) begin : g_bad_phase_len
    $error("sm83_alu_pch_sequencer: PCH_CYCLES and EVAL_CYCLES must be >= 1");
  end

  localparam int unsigned CNT_W = cnt_width(PCH_CYCLES, EVAL_CYCLES);
  localparam logic [CNT_W-1:0] PCH_LOAD  = CNT_W'(PCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] EVAL_LOAD = CNT_W'(EVAL_CYCLES - 1);

  alu_pch_state_t   state_q, state_d;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_zero;
  logic             capture;

  logic [WIDTH-1:0] d_q;
  logic             pch_n_q;
  logic [WIDTH-1:0] pd_q;
  logic             busy_q;
  logic             ack_q;
  logic [WIDTH-1:0] q_q;

  sm83_pch_phase_counter #(
    .CNT_W (CNT_W)
  ) u_phase_cnt (
    .clk        (clk),
    .rst_i      (reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // Next-state logic and phase-counter control.
  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    capture      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          capture      = 1'b1;
          cnt_load     = 1'b1;
          cnt_load_val = PCH_LOAD;
          state_d      = PCH;
        end
      end
      PCH: begin
        if (cnt_zero) begin
          cnt_load     = 1'b1;
          cnt_load_val = EVAL_LOAD;
          state_d      = EVAL;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      EVAL: begin
        if (cnt_zero) begin
          state_d = SAMPLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      SAMPLE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Pull-down pattern captured when a request is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_q <= '0;
    end else if (capture) begin
      d_q <= data;
    end
  end

  // Output registers follow the state one cycle behind, so the pull-downs are
  // still applied on the edge that samples y, and ack/q appear together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pch_n_q <= 1'b0;
      pd_q    <= '0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      q_q     <= '0;
    end else begin
      pch_n_q <= (state_q == EVAL) || (state_q == SAMPLE);
      pd_q    <= (state_q == EVAL) ? d_q : '0;
      busy_q  <= (state_d != IDLE);
      ack_q   <= (state_q == SAMPLE);
      if (state_q == SAMPLE) begin
        q_q <= y;
      end
    end
  end

  assign pch_n = pch_n_q;
  assign pd    = pd_q;
  assign busy  = busy_q;
  assign ack   = ack_q;
  assign q     = q_q;

  a_no_pch_pd_fight: assert property (@(posedge clk) disable iff (reset)
    !(!pch_n_q && (pd_q != '0)));

  a_pd_only_in_eval: assert property (@(posedge clk) disable iff (reset)
    (pd_q != '0) |-> ($past(state_q) == EVAL));

endmodule
